// File: rtl/tdc_pkg.sv
// Shared types and default timing for the TDC register-write port.
// The FSM encoding is exported so checkers can decode the debug state output.
package tdc_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 28;
    localparam int CMD_W  = ADDR_W + DATA_W;

    localparam int T_SETUP_DEF    = 2;
    localparam int T_WR_DEF       = 3;
    localparam int T_HOLD_DEF     = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } tdc_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tdc_cmd_fifo.sv
// Command queue: {addr, data} words, power-of-two depth, extra pointer bit
// distinguishes full from empty. Push while full and pop while empty are ignored.
module tdc_cmd_fifo
    import tdc_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wdata,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/tdc_reg_write.sv
// Queued register-write sequencer for the TDC bus: generates CSN/WRN timing
// with registered bus outputs, one completed write per queued command.
module tdc_reg_write
    import tdc_pkg::*;
#(
    parameter int T_SETUP    = T_SETUP_DEF,
    parameter int T_WR       = T_WR_DEF,
    parameter int T_HOLD     = T_HOLD_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_busy,
    output logic              wr_ready,
    output logic              busy,
    output logic              wr_done,
    output logic              ovf,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              CSN,
    output logic              WRN,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(max3(T_SETUP, T_WR, T_HOLD)) + 1;

    // Handshake: a command is accepted on any rising edge where wr_req and
    // wr_ready are both high; wr_req with wr_ready low is dropped and flags ovf.

    logic [1:0]       rst_pipe;
    logic             rst;
    tdc_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             csn_n, wrn_n, oe_n, done_n, pop;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [CMD_W-1:0] head;
    logic             full, empty;

    // Assert immediately, release two clocks after reset falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_pipe <= 2'b11;
        else       rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst = rst_pipe[1];

    tdc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_req),
        .pop   (pop),
        .wdata ({addr_in, data_in}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign wr_ready  = !full;
    assign busy      = !empty || (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        csn_n   = CSN;
        wrn_n   = WRN;
        oe_n    = data_oe;
        done_n  = 1'b0;
        addr_n  = addr_out;
        data_n  = data_out;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !rd_busy) begin
                    pop             = 1'b1;
                    {addr_n, data_n} = head;
                    csn_n           = 1'b0;
                    wrn_n           = 1'b1;
                    oe_n            = 1'b1;
                    cnt_n           = '0;
                    state_n         = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(T_SETUP - 1)) begin
                    wrn_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = STROBE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == CNT_W'(T_WR - 1)) begin
                    wrn_n   = 1'b1;
                    csn_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(T_HOLD - 1)) begin
                    oe_n    = 1'b0;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            CSN      <= 1'b1;
            WRN      <= 1'b1;
            data_oe  <= 1'b0;
            wr_done  <= 1'b0;
            addr_out <= '0;
            data_out <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            CSN      <= csn_n;
            WRN      <= wrn_n;
            data_oe  <= oe_n;
            wr_done  <= done_n;
            addr_out <= addr_n;
            data_out <= data_n;
            if (wr_req && full) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_reg_write.sv
// Directed bench for tdc_reg_write: default timing instance plus a 1/1/1 timing instance.
module tb_tdc_reg_write;
    import tdc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [3:0]  addr_in;
    logic [27:0] data_in;
    logic        rd_busy;

    logic        wr_ready, busy, wr_done, ovf, data_oe, CSN, WRN;
    logic [3:0]  addr_out;
    logic [27:0] data_out;
    logic [1:0]  state_dbg;

    logic        f_wr_ready, f_busy, f_wr_done, f_ovf, f_data_oe, f_CSN, f_WRN;
    logic [3:0]  f_addr_out;
    logic [27:0] f_data_out;
    logic [1:0]  f_state_dbg;

    int checks = 0;
    int errors = 0;

    int          done_cnt;
    logic [31:0] got_q[$];
    int          csn_len_q[$];
    int          wrn_len_q[$];
    int          oe_len_q[$];
    int          wrn_off_q[$];
    int          gap_q[$];
    int          csn_run, wrn_run, oe_run, hi_run;
    bit          seen_write;

    tdc_reg_write dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .addr_in(addr_in), .data_in(data_in),
        .rd_busy(rd_busy), .wr_ready(wr_ready), .busy(busy), .wr_done(wr_done), .ovf(ovf),
        .addr_out(addr_out), .data_out(data_out), .data_oe(data_oe), .CSN(CSN), .WRN(WRN),
        .state_dbg(state_dbg)
    );

    tdc_reg_write #(.T_SETUP(1), .T_WR(1), .T_HOLD(1)) dut_fast (
        .clk(clk), .reset(reset), .wr_req(wr_req), .addr_in(addr_in), .data_in(data_in),
        .rd_busy(rd_busy), .wr_ready(f_wr_ready), .busy(f_busy), .wr_done(f_wr_done), .ovf(f_ovf),
        .addr_out(f_addr_out), .data_out(f_data_out), .data_oe(f_data_oe), .CSN(f_CSN), .WRN(f_WRN),
        .state_dbg(f_state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // bus monitor on the default instance, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_done) begin
            done_cnt++;
            got_q.push_back({addr_out, data_out});
        end
        if (!CSN) begin
            if (csn_run == 0) begin
                if (seen_write) gap_q.push_back(hi_run);
                seen_write = 1'b1;
            end
            csn_run++;
            hi_run = 0;
        end else begin
            if (csn_run > 0) csn_len_q.push_back(csn_run);
            csn_run = 0;
            hi_run++;
        end
        if (!WRN) begin
            if (wrn_run == 0) wrn_off_q.push_back(csn_run - 1);
            wrn_run++;
        end else begin
            if (wrn_run > 0) wrn_len_q.push_back(wrn_run);
            wrn_run = 0;
        end
        if (data_oe) oe_run++;
        else begin
            if (oe_run > 0) oe_len_q.push_back(oe_run);
            oe_run = 0;
        end
    end

    // driver tasks
    task automatic clear_mon();
        done_cnt = 0;
        got_q.delete();
        csn_len_q.delete();
        wrn_len_q.delete();
        oe_len_q.delete();
        wrn_off_q.delete();
        gap_q.delete();
        csn_run = 0;
        wrn_run = 0;
        oe_run = 0;
        hi_run = 0;
        seen_write = 1'b0;
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [27:0] d);
        wr_req  = 1'b1;
        addr_in = a;
        data_in = d;
        @(posedge clk); #1;
        wr_req  = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
        checks++;
        if (done_cnt < n) begin
            errors++;
            $display("FAIL wait_done: got %0d wr_done pulses, required %0d", done_cnt, n);
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b0; wr_req = 1'b0; rd_busy = 1'b0; addr_in = '0; data_in = '0;
        #1 reset = 1'b1;
        #1;
        checks++; if (CSN !== 1'b1)      begin errors++; $display("FAIL reset_csn: got %b want 1", CSN); end
        checks++; if (WRN !== 1'b1)      begin errors++; $display("FAIL reset_wrn: got %b want 1", WRN); end
        checks++; if (data_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe: got %b want 0", data_oe); end
        checks++; if (wr_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", wr_done); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (addr_out !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_out); end
        checks++; if (data_out !== 28'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (CSN !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset: CSN %b busy %b want 1 0", CSN, busy);
        end
    endtask

    task automatic test_single();
        clear_mon();
        push_cmd(4'h1, 28'h0A5_5A5A);
        @(negedge clk);
        checks++; if (CSN !== 1'b1) begin errors++; $display("FAIL single_lat_early: CSN %b want 1", CSN); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (CSN !== 1'b0 || WRN !== 1'b1 || data_oe !== 1'b1) begin
            errors++; $display("FAIL single_start: CSN %b WRN %b oe %b want 0 1 1", CSN, WRN, data_oe);
        end
        checks++; if (addr_out !== 4'h1 || data_out !== 28'h0A55A5A) begin
            errors++; $display("FAIL single_bus: addr %h data %h want 1 0a55a5a", addr_out, data_out);
        end
        wait_done(1, 40);
        repeat (3) @(negedge clk);
        checks++; if (csn_len_q.size() != 1 || csn_len_q[0] != 5) begin
            errors++; $display("FAIL single_csn_len: n %0d len %0d want 1 5", csn_len_q.size(), (csn_len_q.size() > 0) ? csn_len_q[0] : -1);
        end
        checks++; if (wrn_len_q.size() != 1 || wrn_len_q[0] != 3) begin
            errors++; $display("FAIL single_wrn_len: n %0d len %0d want 1 3", wrn_len_q.size(), (wrn_len_q.size() > 0) ? wrn_len_q[0] : -1);
        end
        checks++; if (wrn_off_q.size() != 1 || wrn_off_q[0] != 2) begin
            errors++; $display("FAIL single_wrn_off: n %0d off %0d want 1 2", wrn_off_q.size(), (wrn_off_q.size() > 0) ? wrn_off_q[0] : -1);
        end
        checks++; if (oe_len_q.size() != 1 || oe_len_q[0] != 7) begin
            errors++; $display("FAIL single_oe_len: n %0d len %0d want 1 7", oe_len_q.size(), (oe_len_q.size() > 0) ? oe_len_q[0] : -1);
        end
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done: pulses %0d busy %b want 1 0", done_cnt, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            wr_req  = 1'b1;
            addr_in = 4'(i);
            data_in = 28'h0100000 + 28'(i);
            @(posedge clk); #1;
        end
        wr_req = 1'b0;
        wait_done(4, 200);
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", done_cnt); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {4'(i), 28'h0100000 + 28'(i)}) begin
                errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got_q[i], {4'(i), 28'h0100000 + 28'(i)});
            end
        end
        checks++; if (gap_q.size() != 3) begin errors++; $display("FAIL b2b_gaps: got %0d gaps want 3", gap_q.size()); end
        for (int i = 0; i < gap_q.size(); i++) begin
            checks++;
            if (gap_q[i] != 3) begin errors++; $display("FAIL b2b_gap[%0d]: CSN high %0d cycles want 3", i, gap_q[i]); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        clear_mon();
        rd_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_req  = 1'b1;
            addr_in = 4'(4 + i);
            data_in = 28'h0200000 + 28'(i);
            @(posedge clk); #1;
            if (i == 3) begin
                checks++; if (wr_ready !== 1'b0 || ovf !== 1'b0) begin
                    errors++; $display("FAIL ovf_full: wr_ready %b ovf %b want 0 0", wr_ready, ovf);
                end
            end
        end
        wr_req = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (done_cnt != 0 || CSN !== 1'b1) begin
            errors++; $display("FAIL ovf_hold_off: pulses %0d CSN %b want 0 1", done_cnt, CSN);
        end
        rd_busy = 1'b0;
        wait_done(4, 200);
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", done_cnt); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][31:28] !== 4'(4 + i)) begin
                errors++; $display("FAIL ovf_order[%0d]: addr %h want %h", i, got_q[i][31:28], 4'(4 + i));
            end
        end
        checks++; if (ovf !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky: ovf %b busy %b want 1 0", ovf, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rd_busy_mid();
        int i;
        clear_mon();
        wr_req = 1'b1; addr_in = 4'hA; data_in = 28'h0300000;
        @(posedge clk); #1;
        addr_in = 4'hB; data_in = 28'h0300001;
        @(posedge clk); #1;
        wr_req = 1'b0;
        for (i = 0; i < 40 && WRN !== 1'b0; i++) @(negedge clk);
        checks++; if (WRN !== 1'b0) begin errors++; $display("FAIL rdb_strobe: WRN %b want 0", WRN); end
        rd_busy = 1'b1;
        wait_done(1, 40);
        repeat (10) @(negedge clk);
        checks++; if (done_cnt != 1 || CSN !== 1'b1) begin
            errors++; $display("FAIL rdb_hold_off: pulses %0d CSN %b want 1 1", done_cnt, CSN);
        end
        checks++; if (busy !== 1'b1 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL rdb_idle: busy %b state %0d want 1 0", busy, state_dbg);
        end
        rd_busy = 1'b0;
        wait_done(2, 40);
        checks++; if (got_q.size() != 2 || got_q[0][31:28] !== 4'hA || got_q[1][31:28] !== 4'hB) begin
            errors++; $display("FAIL rdb_order: n %0d want 2 writes A then B", got_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int i;
        clear_mon();
        push_cmd(4'hC, 28'h0400000);
        for (i = 0; i < 40 && WRN !== 1'b0; i++) @(negedge clk);
        @(posedge clk); #1;
        checks++; if (WRN !== 1'b0) begin errors++; $display("FAIL rmid_strobe: WRN %b want 0", WRN); end
        reset = 1'b1;
        #1;
        checks++; if (CSN !== 1'b1 || WRN !== 1'b1 || data_oe !== 1'b0) begin
            errors++; $display("FAIL rmid_async: CSN %b WRN %b oe %b want 1 1 0", CSN, WRN, data_oe);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done_cnt != 0) begin
            errors++; $display("FAIL rmid_after: busy %b pulses %0d want 0 0", busy, done_cnt);
        end
        checks++; if (ovf !== 1'b0 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL rmid_clear: ovf %b state %0d want 0 0", ovf, state_dbg);
        end
    endtask

    task automatic test_fast_timing();
        int n_csn, n_wrn, n_oe, n_done;
        n_csn = 0; n_wrn = 0; n_oe = 0; n_done = 0;
        push_cmd(4'hD, 28'h1234567);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!f_CSN)    n_csn++;
            if (!f_WRN)    n_wrn++;
            if (f_data_oe) n_oe++;
            if (f_wr_done) n_done++;
        end
        checks++; if (n_csn != 2) begin errors++; $display("FAIL fast_csn: got %0d want 2", n_csn); end
        checks++; if (n_wrn != 1) begin errors++; $display("FAIL fast_wrn: got %0d want 1", n_wrn); end
        checks++; if (n_oe != 3)  begin errors++; $display("FAIL fast_oe: got %0d want 3", n_oe); end
        checks++; if (n_done != 1 || f_addr_out !== 4'hD || f_data_out !== 28'h1234567) begin
            errors++; $display("FAIL fast_done: pulses %0d addr %h data %h want 1 d 1234567", n_done, f_addr_out, f_data_out);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_rd_busy_mid();
        test_reset_mid();
        test_fast_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
